// File: rtl/ddr_cmd_scheduler_if.sv
// Bundle between ddr_cmd_scheduler, its requesters, and the DDR3 command SM.
// Requests are levels held until their one-cycle ack; a request dropped before it is granted is not served.
// A command strobe stays high until the SM drops sm_idle, which counts as the accept.
// The SM raising sm_idle again marks the command as done.
interface ddr_cmd_scheduler_if;
  logic        wr_req;
  logic        wr_ack;
  logic        rd_req;
  logic        rd_ack;
  logic        sm_idle;
  logic        WRITE;
  logic        READ;
  logic        REF;
  logic [3:0]  ref_pending;
  logic        ref_urgent;
  logic        timeout_err;
  logic [15:0] wr_count;
  logic [15:0] rd_count;
  logic [15:0] ref_count;

  modport slave (
    input  wr_req, rd_req, sm_idle,
    output wr_ack, rd_ack, WRITE, READ, REF,
    output ref_pending, ref_urgent, timeout_err,
    output wr_count, rd_count, ref_count
  );

  modport master (
    output wr_req, rd_req, sm_idle,
    input  wr_ack, rd_ack, WRITE, READ, REF,
    input  ref_pending, ref_urgent, timeout_err,
    input  wr_count, rd_count, ref_count
  );
endinterface

// File: rtl/ddr_cmd_scheduler.sv
// Arbitrates the DDR3 command SM between refresh, write and read, and tracks postponed refresh credits.
// Define SCHED_STATS_EN to build the wr/rd/ref completion counters; otherwise they read as 0.
module ddr_cmd_scheduler #(
  parameter int TREFI_CYC    = 6400000,
  parameter int POSTPONE_MAX = 8,
  parameter int CMD_TIMEOUT  = 1024
) (
  input  logic               CLK,
  input  logic               RESET_n,
  ddr_cmd_scheduler_if.slave bus,
  output logic [1:0]         o_dbg_state
);

  localparam int TW = (TREFI_CYC > 1) ? $clog2(TREFI_CYC) : 1;
  localparam int CW = (CMD_TIMEOUT > 1) ? $clog2(CMD_TIMEOUT) : 1;
  localparam logic [TW-1:0] TREFI_LAST = TW'(TREFI_CYC - 1);
  localparam logic [CW-1:0] TO_LAST    = CW'(CMD_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_ACK       = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    C_NONE = 2'd0,
    C_WR   = 2'd1,
    C_RD   = 2'd2,
    C_REF  = 2'd3
  } cmd_t;

  state_t        r_state, w_state_nxt;
  cmd_t          r_cmd, w_cmd_nxt, w_pick;
  logic [TW-1:0] r_timer;
  logic [CW-1:0] r_to_cnt, w_to_nxt;
  logic [3:0]    r_ref_pending;
  logic          r_last_grant, w_last_grant_nxt;  // 1: write was granted last
  logic          r_timeout_err, w_timeout_set;
  logic          w_wrap, w_ref_done, w_ref_urgent;

  // ---------------------------------------------------------------
  // Refresh credit tracking
  // ---------------------------------------------------------------
  assign w_wrap       = (r_timer == TREFI_LAST);
  assign w_ref_done   = (r_state == S_ACK) && (r_cmd == C_REF);
  assign w_ref_urgent = (int'({28'd0, r_ref_pending}) >= POSTPONE_MAX);

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_timer <= '0;
    end else begin
      r_timer <= w_wrap ? '0 : r_timer + TW'(1);
    end
  end

  // A credit earned and a refresh retired in the same cycle cancel out.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_ref_pending <= 4'd0;
    end else if (w_wrap && !w_ref_done) begin
      if (r_ref_pending != 4'hF) r_ref_pending <= r_ref_pending + 4'd1;
    end else if (w_ref_done && !w_wrap) begin
      if (r_ref_pending != 4'd0) r_ref_pending <= r_ref_pending - 4'd1;
    end
  end

  // ---------------------------------------------------------------
  // Grant selection
  // ---------------------------------------------------------------
  always_comb begin
    w_pick = C_NONE;
    if (w_ref_urgent) begin
      w_pick = C_REF;
    end else if (bus.wr_req && bus.rd_req) begin
      w_pick = r_last_grant ? C_RD : C_WR;
    end else if (bus.wr_req) begin
      w_pick = C_WR;
    end else if (bus.rd_req) begin
      w_pick = C_RD;
    end else if (r_ref_pending != 4'd0) begin
      w_pick = C_REF;
    end
  end

  // ---------------------------------------------------------------
  // Command FSM
  // ---------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_state       <= S_IDLE;
      r_cmd         <= C_NONE;
      r_to_cnt      <= '0;
      r_last_grant  <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cmd        <= w_cmd_nxt;
      r_to_cnt     <= w_to_nxt;
      r_last_grant <= w_last_grant_nxt;
      if (w_timeout_set) r_timeout_err <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cmd_nxt        = r_cmd;
    w_to_nxt         = r_to_cnt;
    w_last_grant_nxt = r_last_grant;
    w_timeout_set    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_cmd_nxt = C_NONE;
        if (bus.sm_idle && (w_pick != C_NONE)) begin
          w_state_nxt = S_ISSUE;
          w_cmd_nxt   = w_pick;
          w_to_nxt    = '0;
        end
      end
      // Timeout wins over a same-cycle accept or done: the command is abandoned.
      S_ISSUE: begin
        if (r_to_cnt == TO_LAST) begin
          w_timeout_set = 1'b1;
          w_state_nxt   = S_IDLE;
          w_cmd_nxt     = C_NONE;
        end else begin
          w_to_nxt = r_to_cnt + CW'(1);
          if (!bus.sm_idle) w_state_nxt = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (r_to_cnt == TO_LAST) begin
          w_timeout_set = 1'b1;
          w_state_nxt   = S_IDLE;
          w_cmd_nxt     = C_NONE;
        end else begin
          w_to_nxt = r_to_cnt + CW'(1);
          if (bus.sm_idle) w_state_nxt = S_ACK;
        end
      end
      S_ACK: begin
        w_state_nxt = S_IDLE;
        w_cmd_nxt   = C_NONE;
        if (r_cmd == C_WR) w_last_grant_nxt = 1'b1;
        if (r_cmd == C_RD) w_last_grant_nxt = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cmd_nxt   = C_NONE;
      end
    endcase
  end

  // Strobes and acks decode straight from registered state so reset clears them at once.
  assign bus.WRITE       = (r_state == S_ISSUE) && (r_cmd == C_WR);
  assign bus.READ        = (r_state == S_ISSUE) && (r_cmd == C_RD);
  assign bus.REF         = (r_state == S_ISSUE) && (r_cmd == C_REF);
  assign bus.wr_ack      = (r_state == S_ACK) && (r_cmd == C_WR);
  assign bus.rd_ack      = (r_state == S_ACK) && (r_cmd == C_RD);
  assign bus.ref_pending = r_ref_pending;
  assign bus.ref_urgent  = w_ref_urgent;
  assign bus.timeout_err = r_timeout_err;
  assign o_dbg_state     = r_state;

  // ---------------------------------------------------------------
  // Completion statistics
  // ---------------------------------------------------------------
`ifdef SCHED_STATS_EN
  logic [15:0] r_wr_count, r_rd_count, r_ref_count;

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_wr_count  <= 16'd0;
      r_rd_count  <= 16'd0;
      r_ref_count <= 16'd0;
    end else if (r_state == S_ACK) begin
      if (r_cmd == C_WR)  r_wr_count  <= r_wr_count + 16'd1;
      if (r_cmd == C_RD)  r_rd_count  <= r_rd_count + 16'd1;
      if (r_cmd == C_REF) r_ref_count <= r_ref_count + 16'd1;
    end
  end

  assign bus.wr_count  = r_wr_count;
  assign bus.rd_count  = r_rd_count;
  assign bus.ref_count = r_ref_count;
`else
  assign bus.wr_count  = 16'd0;
  assign bus.rd_count  = 16'd0;
  assign bus.ref_count = 16'd0;
`endif

endmodule

// File: tb/tb_ddr_cmd_scheduler.sv
// Randomized bench for ddr_cmd_scheduler: a reactive command-SM model, random requesters,
// and a transaction-level reference model of arbitration and refresh credits.
module tb_ddr_cmd_scheduler;
  localparam int TREFI = 40;
  localparam int PMAX  = 8;
  localparam int TOUT  = 16;
  localparam int K_NONE = 0, K_WR = 1, K_RD = 2, K_REF = 3;
`ifdef SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  ddr_cmd_scheduler_if bus();

  ddr_cmd_scheduler #(.TREFI_CYC(TREFI), .POSTPONE_MAX(PMAX), .CMD_TIMEOUT(TOUT)) dut (
    .CLK(clk), .RESET_n(rst_n), .bus(bus), .o_dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];
  int grant_log[$];
  logic [1:0] prev_code;

  // reference model: one transaction in flight plus refresh credit bookkeeping
  int m_timer, m_pend, m_kind, m_age, m_wcnt, m_rcnt, m_fcnt;
  bit m_acc, m_done, m_wr_last, m_terr;

  // command-SM model and stimulus knobs
  int sm_phase, sm_left;
  bit force_busy, no_accept, stuck, coincide, hold_wr, hold_rd, rand_req;

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_timer = 0; m_pend = 0; m_kind = K_NONE; m_age = 0;
    m_wcnt = 0; m_rcnt = 0; m_fcnt = 0;
    m_acc = 0; m_done = 0; m_wr_last = 0; m_terr = 0;
    exp_q.delete();
    prev_code = 2'd0;
  endtask

  task automatic model_step(input bit wr, input bit rd, input bit idle);
    int  p;
    int  pick;
    bit  wrap;
    bit  ref_fin;
    p       = m_pend;
    wrap    = (m_timer == TREFI - 1);
    ref_fin = m_done && (m_kind == K_REF);
    m_timer = wrap ? 0 : m_timer + 1;
    if (wrap && !ref_fin) m_pend = (m_pend < 15) ? m_pend + 1 : 15;
    else if (ref_fin && !wrap && m_pend > 0) m_pend = m_pend - 1;

    if (m_kind == K_NONE) begin
      pick = K_NONE;
      if (idle) begin
        if (p >= PMAX) pick = K_REF;
        else if (wr && rd) pick = m_wr_last ? K_RD : K_WR;
        else if (wr) pick = K_WR;
        else if (rd) pick = K_RD;
        else if (p > 0) pick = K_REF;
      end
      if (pick != K_NONE) begin
        m_kind = pick; m_age = 0; m_acc = 0; m_done = 0;
        exp_q.push_back(2'(pick));
      end
    end else if (m_done) begin
      if (m_kind == K_WR) begin m_wr_last = 1; m_wcnt++; end
      if (m_kind == K_RD) begin m_wr_last = 0; m_rcnt++; end
      if (m_kind == K_REF) m_fcnt++;
      m_kind = K_NONE; m_done = 0; m_acc = 0;
    end else if (m_age == TOUT - 1) begin
      m_terr = 1; m_kind = K_NONE; m_acc = 0;
    end else begin
      if (!m_acc) begin
        if (!idle) m_acc = 1;
      end else if (idle) begin
        m_done = 1;
      end
      m_age++;
    end
  endtask

  function automatic logic [2:0] exp_strobe();
    bit issuing;
    issuing = (m_kind != K_NONE) && !m_acc;
    return {issuing && m_kind == K_WR, issuing && m_kind == K_RD, issuing && m_kind == K_REF};
  endfunction

  function automatic logic [1:0] exp_ack();
    return {m_done && m_kind == K_WR, m_done && m_kind == K_RD};
  endfunction

  function automatic logic [1:0] code_of(input logic [2:0] s);
    case (s)
      3'b100:  return 2'd1;
      3'b010:  return 2'd2;
      3'b001:  return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // driver: SM reaction and requester behaviour for the next cycle
  task automatic drive();
    bit issuing;
    logic [1:0] a;
    issuing = (exp_strobe() != 3'd0);
    a = exp_ack();
    if (force_busy) begin
      bus.sm_idle = 1'b0;
    end else if (sm_phase == 0) begin
      bus.sm_idle = 1'b1;
      if (issuing && !no_accept) begin
        if (sm_left > 0) sm_left--;
        else begin sm_phase = 1; sm_left = $urandom_range(1, 6); bus.sm_idle = 1'b0; end
      end else if (rand_req && !issuing && $urandom_range(0, 29) == 0) begin
        sm_phase = 1; sm_left = $urandom_range(1, 4); bus.sm_idle = 1'b0;
      end
    end else begin
      bus.sm_idle = 1'b0;
      if (coincide) begin
        if (m_timer == TREFI - 2) begin sm_phase = 0; sm_left = 0; bus.sm_idle = 1'b1; end
      end else if (!stuck) begin
        if (sm_left > 0) sm_left--;
        else begin sm_phase = 0; sm_left = $urandom_range(0, 2); bus.sm_idle = 1'b1; end
      end
    end

    if (hold_wr) bus.wr_req = 1'b1;
    else if (!rand_req) bus.wr_req = 1'b0;
    else if (bus.wr_req) begin
      if (a[1] || $urandom_range(0, 49) == 0) bus.wr_req = 1'b0;
    end else if ($urandom_range(0, 3) == 0) bus.wr_req = 1'b1;

    if (hold_rd) bus.rd_req = 1'b1;
    else if (!rand_req) bus.rd_req = 1'b0;
    else if (bus.rd_req) begin
      if (a[0] || $urandom_range(0, 49) == 0) bus.rd_req = 1'b0;
    end else if ($urandom_range(0, 3) == 0) bus.rd_req = 1'b1;
  endtask

  // one clock: advance the model on the edge, compare 1 time unit later, then drive
  task automatic cycle();
    bit wr, rd, idl;
    logic [2:0] st;
    logic [1:0] code;
    @(posedge clk);
    wr = bus.wr_req; rd = bus.rd_req; idl = bus.sm_idle;
    if (rst_n) model_step(wr, rd, idl);
    else model_reset();
    #1;
    st = {bus.WRITE, bus.READ, bus.REF};
    check("strobes", st, exp_strobe());
    check("acks", {bus.wr_ack, bus.rd_ack}, exp_ack());
    check("refstat", {bus.ref_pending, bus.ref_urgent, bus.timeout_err},
          {4'(m_pend), m_pend >= PMAX, m_terr});
    check("counters", {bus.wr_count, bus.rd_count, bus.ref_count},
          STATS ? {16'(m_wcnt), 16'(m_rcnt), 16'(m_fcnt)} : 48'd0);
    code = code_of(st);
    if (code != 2'd0 && prev_code == 2'd0) begin
      grant_log.push_back(int'(code));
      check("grant", code, (exp_q.size() > 0) ? exp_q.pop_front() : 2'd0);
    end
    prev_code = code;
    drive();
  endtask

  task automatic clear_knobs();
    force_busy = 0; no_accept = 0; stuck = 0; coincide = 0;
    hold_wr = 0; hold_rd = 0; rand_req = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_knobs();
    bus.wr_req = 1'b0; bus.rd_req = 1'b0;
    repeat (2) cycle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int run;
    int runs[$];
    int n;
    bus.wr_req = 1'b0; bus.rd_req = 1'b0; bus.sm_idle = 1'b1;
    sm_phase = 0; sm_left = 0;
    clear_knobs();
    model_reset();

    // reset state
    repeat (3) cycle();
    @(negedge clk);
    rst_n = 1'b1;

    // both requests held: write first, then alternate
    hold_wr = 1; hold_rd = 1;
    grant_log.delete();
    n = 0;
    for (int i = 0; i < 200 && n < 4; i++) begin
      cycle();
      n = 0;
      foreach (grant_log[j]) if (grant_log[j] != K_REF) n++;
    end
    check("alt_count", n, 4);
    n = 0;
    foreach (grant_log[j]) begin
      if (grant_log[j] != K_REF && n < 4) begin
        check($sformatf("alt_order%0d", n), grant_log[j], (n % 2 == 0) ? K_WR : K_RD);
        n++;
      end
    end
    hold_wr = 0; hold_rd = 0;
    repeat (20) cycle();

    // randomized traffic with SM stalls
    rand_req = 1;
    for (int i = 0; i < 3000; i++) begin
      cycle();
      if (errors > 30) break;
    end
    rand_req = 0;
    repeat (20) cycle();

    // SM stuck busy: credits pile up, then refresh preempts a held write
    hold_wr = 1; force_busy = 1;
    repeat (420) cycle();
    check("urgent_set", bus.ref_urgent, 1'b1);
    force_busy = 0;
    grant_log.delete();
    for (int i = 0; i < 600; i++) begin
      cycle();
      if (grant_log.size() > 0 && grant_log[grant_log.size() - 1] == K_WR) break;
    end
    check("urgent_first_is_ref", (grant_log.size() > 0) ? grant_log[0] : K_NONE, K_REF);
    check("urgent_then_write", (grant_log.size() > 0) ? grant_log[grant_log.size() - 1] : K_NONE, K_WR);
    hold_wr = 0;
    repeat (20) cycle();

    // SM never accepts: WRITE held exactly TOUT cycles, then sticky error
    apply_reset();
    hold_wr = 1; no_accept = 1;
    run = 0;
    runs.delete();
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (bus.WRITE) run++;
      else if (run > 0) begin runs.push_back(run); run = 0; end
    end
    check("timeout_len", (runs.size() > 0) ? runs[0] : 0, TOUT);
    check("timeout_err", bus.timeout_err, 1'b1);
    hold_wr = 0; no_accept = 0;
    repeat (10) cycle();

    // SM accepts but never finishes: timeout out of the wait phase
    hold_rd = 1; stuck = 1;
    repeat (40) cycle();
    hold_rd = 0; stuck = 0;
    repeat (20) cycle();

    // refresh completion lands on a timer wrap
    apply_reset();
    force_busy = 1;
    for (int i = 0; i < 200 && !(m_pend >= 1 && m_timer == TREFI - 12); i++) cycle();
    force_busy = 0; coincide = 1;
    sm_phase = 0; sm_left = 0; bus.sm_idle = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (m_timer == 0) break;
    end
    check("coincide_pend", bus.ref_pending, 4'd1);
    coincide = 0;
    repeat (10) cycle();

    // reset asserted while a write waits for completion
    hold_wr = 1;
    for (int i = 0; i < 60 && !(m_acc && !m_done); i++) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", {bus.WRITE, bus.READ, bus.REF, bus.wr_ack, bus.rd_ack, bus.ref_pending,
                        bus.ref_urgent, bus.timeout_err, bus.wr_count, dbg_state}, 48'd0);
    model_reset();
    clear_knobs();
    bus.wr_req = 1'b0; bus.rd_req = 1'b0;
    repeat (2) cycle();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ddr_cmd_scheduler.md
Name: ddr_cmd_scheduler

Overview:
- Arbitrates the single DDR3 command state machine between three requesters: the internal refresh timer, a write requester and a read requester.
- Drives level-held WRITE/READ/REF command strobes into the SM and watches its idle indication for accept and done.
- Returns one-cycle acks to requesters.
- Replaces the free-running refresh comparator at top level and supports postponed refresh (up to POSTPONE_MAX owed).

Parameters:
- TREFI_CYC, 6400000, CLK cycles between refresh credits.
- POSTPONE_MAX, 8, owed-refresh count at which refresh becomes urgent.
- CMD_TIMEOUT, 1024, max cycles in ISSUE or WAIT_DONE before abort.

Ports:
- CLK  input  1  system clock, all logic on rising edge
- RESET_n  input  1  asynchronous active-low reset
- wr_req  input  1  write request, level, held until wr_ack
- wr_ack  output  1  one-cycle pulse: write completed
- rd_req  input  1  read request, level, held until rd_ack
- rd_ack  output  1  one-cycle pulse: read completed
- sm_idle  input  1  command SM in idle/ready state
- WRITE  output  1  write command strobe to SM
- READ  output  1  read command strobe to SM
- REF  output  1  refresh command strobe to SM
- ref_pending  output  4  refreshes owed
- ref_urgent  output  1  ref_pending >= POSTPONE_MAX
- timeout_err  output  1  sticky: a command timed out
- wr_count  output  16  completed writes (see Optional Feature)
- rd_count  output  16  completed reads
- ref_count  output  16  completed refreshes

Behaviour:
- Reset (async assert, sync release): state IDLE. All strobes, acks, timeout_err, ref_pending, refresh timer and last_grant are 0. last_grant=0 means write has priority next.
- Refresh timer:
  - Counts 0..TREFI_CYC-1 and wraps.
  - On wrap, ref_pending increments, saturating at 15.
  - A refresh completing in the same cycle as a wrap leaves ref_pending unchanged.
  - Completion with no wrap decrements ref_pending, never below 0.
- States: IDLE, ISSUE, WAIT_DONE, ACK.
- IDLE: grants only when sm_idle=1. Priority order:
  1. ref_urgent → REF.
  2. Both wr_req and rd_req → grant the one not equal to last_grant.
  3. Single wr_req or rd_req → that request.
  4. ref_pending>0 → REF.
  5. Otherwise stay in IDLE.
  - On grant: latch the command type, go to ISSUE, clear the timeout counter.
- ISSUE:
  - The selected strobe is high for every cycle in ISSUE; only one strobe is ever high.
  - When sm_idle goes 0 (SM accepted), the strobe drops next cycle and the state goes to WAIT_DONE.
- WAIT_DONE: when sm_idle returns to 1, go to ACK.
- ACK, one cycle:
  - wr_ack or rd_ack pulses for a granted read/write; refresh has no ack.
  - ref_pending decrements for a refresh.
  - last_grant updates only for read/write grants.
  - Return to IDLE.
- Timeout: the counter runs in ISSUE and WAIT_DONE. On reaching CMD_TIMEOUT:
  - set timeout_err (cleared only by reset);
  - drop the strobe and return to IDLE;
  - no ack, no ref_pending decrement.
- Requester rules:
  - A request deasserted before its grant is simply not served.
  - A request deasserted after grant still completes and still acks.
- Latency: with sm_idle=1 and wr_req asserted in IDLE, WRITE is high on the next cycle.
- Reset mid-operation: all outputs return to 0 immediately; no ack is generated.

Optional Feature:
- Macro: SCHED_STATS_EN.
- Defined: wr_count, rd_count and ref_count increment in ACK for their command type, wrap at 16 bits, and reset to 0.
- Undefined: no counter logic is built; all three ports are tied to 0.

Test Plan:
- TREFI_CYC=100, no requests, SM model drops sm_idle 1 cycle after strobe and raises it 5 cycles later → REF asserted within 2 cycles of the first wrap; ref_pending returns 1→0; ref_count=1 with SCHED_STATS_EN.
- wr_req and rd_req asserted together, held continuously → grant order WRITE, READ, WRITE, READ; each ack one cycle wide.
- sm_idle held 0 for 250 cycles (TREFI_CYC=20) → ref_pending reaches 12 and ref_urgent=1. On release, REF wins over pending wr_req until ref_pending=7, then WRITE is granted.
- sm_idle never deasserts after WRITE, CMD_TIMEOUT=16 → WRITE drops after 16 cycles, timeout_err=1, no wr_ack, state IDLE.
- Refresh completion coincident with a timer wrap → ref_pending unchanged.
- RESET_n pulsed low during WAIT_DONE → all outputs 0 asynchronously, no ack after release, timer restarts at 0.
